mdio_resp: RTL and testbench

//  PHY-side MDIO (IEEE 802.3 cl.22) management responder: far end of the MDC/MDIO master routed via pinmux.

---
 rtl/mdio_pkg.sv | 30 +++
 rtl/mdio_sync_edge.sv | 46 ++++
 rtl/mdio_resp.sv | 233 +++++++++++++++++++++++
 tb/tb_mdio_resp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// +----------------------------------------------------------------------------+
// | mdio_pkg : shared types and constants for the clause-22 MDIO responder     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST    = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        DATA  = 3'd6
    } mdio_state_e;

    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] ST_BITS = 2'b01;
    localparam int         MDIO_DW = 16;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3f) ? v : v + 6'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_sync_edge.sv
// +----------------------------------------------------------------------------+
// | mdio_sync_edge : 2-flop sync of MDC/MDIO plus MDC rise/fall pulses         |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);

    logic mdc_meta_q;
    logic mdc_sync_q;
    logic mdc_prev_q;
    logic mdio_meta_q;
    logic mdio_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_meta_q  <= 1'b0;
            mdc_sync_q  <= 1'b0;
            mdc_prev_q  <= 1'b0;
            mdio_meta_q <= 1'b0;
            mdio_sync_q <= 1'b0;
        end else begin
            mdc_meta_q  <= mdc_in;
            mdc_sync_q  <= mdc_meta_q;
            mdc_prev_q  <= mdc_sync_q;
            mdio_meta_q <= mdio_in;
            mdio_sync_q <= mdio_meta_q;
        end
    end

    // MDIO and MDC see identical sync depth, so mdio_s is aligned with the rise pulse
    assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
    assign mdc_fall = ~mdc_sync_q & mdc_prev_q;
    assign mdio_s   = mdio_sync_q;

endmodule

`default_nettype wire

// File: rtl/mdio_resp.sv
// +----------------------------------------------------------------------------+
// | mdio_resp : PHY-side clause-22 MDIO responder with register strobe bus     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mdio_resp
    import mdio_pkg::*;
#(
    parameter int PRE_LEN = 32,
    parameter int DATA_W  = MDIO_DW
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [4:0]        cfg_phy_addr,
    input  logic              mdc_in,
    input  logic              mdio_in,
    output logic              mdio_out,
    output logic              mdio_out_en,
    output logic [4:0]        reg_addr,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);

    localparam logic [5:0] PRE_MIN   = 6'(PRE_LEN);
    localparam logic [3:0] LAST_DBIT = 4'(DATA_W - 1);

    logic mdc_rise;
    logic mdc_fall;
    logic smp_bit;

    mdio_sync_edge u_sync (
        .clk      (mclk),
        .rst_n    (reset_n),
        .mdc_in   (mdc_in),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_s   (smp_bit)
    );

    mdio_state_e       state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [5:0]        pre_cnt_q, pre_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              is_rd_q, is_rd_d;
    logic              hit_q, hit_d;
    logic [4:0]        regad_q, regad_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic              reg_wr_q, reg_wr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_rd_q, reg_rd_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        cap_q, cap_d;
    logic              out_q, out_d;
    logic              out_en_q, out_en_d;
    logic [1:0]        op_bits;
    logic [4:0]        field_bits;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_rd_q     <= 1'b0;
            hit_q       <= 1'b0;
            regad_q     <= '0;
            reg_addr_q  <= '0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= '0;
            reg_rd_q    <= 1'b0;
            frame_err_q <= 1'b0;
            cap_q       <= '0;
            out_q       <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_rd_q     <= is_rd_d;
            hit_q       <= hit_d;
            regad_q     <= regad_d;
            reg_addr_q  <= reg_addr_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_rd_q    <= reg_rd_d;
            frame_err_q <= frame_err_d;
            cap_q       <= cap_d;
            out_q       <= out_d;
            out_en_q    <= out_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        is_rd_d     = is_rd_q;
        hit_d       = hit_q;
        regad_d     = regad_q;
        reg_addr_d  = reg_addr_q;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        reg_rd_d    = 1'b0;
        frame_err_d = 1'b0;
        out_d       = out_q;
        out_en_d    = out_en_q;
        op_bits     = {rx_q[0], smp_bit};
        field_bits  = {rx_q[3:0], smp_bit};

        // cap_q[1] marks the cycle two clocks after reg_rd, when reg_rdata is guaranteed
        cap_d = {cap_q[0], reg_rd_q};
        if (cap_q[1]) begin
            tx_d = reg_rdata;
        end

        if (mdc_rise) begin
            rx_d = {rx_q[DATA_W-2:0], smp_bit};
            unique case (state_q)
                IDLE: begin
                    if (smp_bit) begin
                        pre_cnt_d = sat_inc6(pre_cnt_q);
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q >= PRE_MIN) begin
                            state_d = ST;
                        end
                    end
                end
                ST: begin
                    if (smp_bit == ST_BITS[0]) begin
                        state_d   = OP;
                        bit_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
                OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else if (op_bits == OP_RD || op_bits == OP_WR) begin
                        is_rd_d   = (op_bits == OP_RD);
                        state_d   = PHYAD;
                        bit_cnt_d = '0;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end
                end
                PHYAD: begin
                    if (bit_cnt_q == 4'd4) begin
                        hit_d     = (field_bits == cfg_phy_addr);
                        state_d   = REGAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                REGAD: begin
                    if (bit_cnt_q == 4'd4) begin
                        regad_d   = field_bits;
                        state_d   = TA;
                        bit_cnt_d = '0;
                        if (hit_q && is_rd_q) begin
                            reg_addr_d = field_bits;
                            reg_rd_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                TA: begin
                    if (bit_cnt_q == 4'd1) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = 4'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == LAST_DBIT) begin
                        state_d   = IDLE;
                        pre_cnt_d = '0;
                        if (hit_q && !is_rd_q) begin
                            reg_wdata_d = {rx_q[DATA_W-2:0], smp_bit};
                            reg_addr_d  = regad_q;
                            reg_wr_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Rise and fall pulses are mutually exclusive, so the drive side never fights the sampler
        if (mdc_fall && hit_q && is_rd_q) begin
            if (state_q == TA && bit_cnt_q == 4'd1) begin
                out_en_d = 1'b1;
                out_d    = 1'b0;
            end else if (state_q == DATA) begin
                out_d = tx_q[DATA_W-1];
                tx_d  = {tx_q[DATA_W-2:0], 1'b0};
            end else if (state_q == IDLE) begin
                out_en_d = 1'b0;
                out_d    = 1'b0;
            end
        end
    end

    assign mdio_out    = out_q;
    assign mdio_out_en = out_en_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr      = reg_wr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_rd      = reg_rd_q;
    assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_resp.sv
// +----------------------------------------------------------------------------+
// | tb_mdio_resp : MDIO master model, register responder and event scoreboard  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mdio_resp;

    localparam int         PRE_LEN = 32;
    localparam logic [4:0] CFG     = 5'h03;

    typedef enum int {K_WR = 0, K_RD = 1, K_ERR = 2, K_RDATA = 3} kind_e;
    typedef struct {
        kind_e       kind;
        logic [4:0]  addr;
        logic [17:0] data;
    } exp_t;

    logic        mclk      = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mdc       = 1'b0;
    logic        master_oe = 1'b0;
    logic        master_d  = 1'b1;
    logic [15:0] reg_rdata = 16'h0;
    logic        mdio_out;
    logic        mdio_out_en;
    logic [4:0]  reg_addr;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        reg_rd;
    logic        frame_err;
    logic        mdio_pad;

    exp_t        exp_q[$];
    int          errors  = 0;
    int          checks  = 0;
    int          en_viol = 0;
    int          rd_age  = 0;
    logic        en_ok     = 1'b0;
    logic [15:0] rd_value  = 16'h0;
    logic        rd_word_v = 1'b0;
    logic [17:0] rd_word   = 18'h0;

    always #5 mclk = ~mclk;

    // Open-drain style pad with pull-up when nobody drives
    assign mdio_pad = mdio_out_en ? mdio_out : (master_oe ? master_d : 1'b1);

    mdio_resp #(.PRE_LEN(PRE_LEN), .DATA_W(16)) dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_phy_addr (CFG),
        .mdc_in       (mdc),
        .mdio_in      (mdio_pad),
        .mdio_out     (mdio_out),
        .mdio_out_en  (mdio_out_en),
        .reg_addr     (reg_addr),
        .reg_wr       (reg_wr),
        .reg_wdata    (reg_wdata),
        .reg_rd       (reg_rd),
        .reg_rdata    (reg_rdata),
        .frame_err    (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take_event(input kind_e k, input logic [4:0] a, input logic [17:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", int'(k), $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            if (k == e.kind && (k == K_WR || k == K_RD)) check("event_addr", 32'(a), 32'(e.addr));
            if (k == e.kind && (k == K_WR || k == K_RDATA)) check("event_data", 32'(d), 32'(e.data));
        end
    endtask

    // Scoreboard monitor: every DUT strobe and every completed master read pops one expectation
    always @(negedge mclk) begin
        if (reset_n) begin
            if (reg_wr || reg_rd) check("rd_wr_exclusive", 32'(reg_wr & reg_rd), 32'd0);
            if (reg_wr) take_event(K_WR, reg_addr, {2'b00, reg_wdata});
            if (reg_rd) take_event(K_RD, reg_addr, 18'h0);
            if (frame_err) take_event(K_ERR, 5'h0, 18'h0);
            if (rd_word_v) take_event(K_RDATA, 5'h0, rd_word);
            if (mdio_out_en && !en_ok) en_viol++;
        end
    end

    // Register-file side: read data becomes valid only two clocks after reg_rd
    always @(negedge mclk) begin
        if (reg_rd) begin
            rd_age    = 1;
            reg_rdata = ~rd_value;
        end else if (rd_age != 0) begin
            rd_age++;
            if (rd_age == 3) begin
                reg_rdata = rd_value;
                rd_age    = 0;
            end
        end
    end

    // Reference model: decides the frame's outcome from its fields alone
    task automatic model(input int pre, input logic [1:0] st, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                         input logic [15:0] rv, input int abort_after,
                         output bit drives, output bit want_data);
        exp_t e;
        drives    = 1'b0;
        want_data = 1'b0;
        if (pre < PRE_LEN) return;
        if (st != 2'b01 || !(op == 2'b10 || op == 2'b01)) begin
            e = '{K_ERR, 5'h0, 18'h0};
            exp_q.push_back(e);
            return;
        end
        if (phy != CFG) return;
        if (op == 2'b10) begin
            e = '{K_RD, ra, 18'h0};
            exp_q.push_back(e);
            drives = 1'b1;
            if (abort_after == 0) begin
                e = '{K_RDATA, 5'h0, {2'b10, rv}};
                exp_q.push_back(e);
                want_data = 1'b1;
            end
        end else begin
            e = '{K_WR, ra, {2'b00, wd}};
            exp_q.push_back(e);
        end
    endtask

    // One MDC cycle: low half (master updates MDIO), sample pad, then high half
    task automatic mbit(input logic drive, input logic b, output logic s);
        mdc       = 1'b0;
        master_oe = drive;
        master_d  = b;
        repeat (5) @(posedge mclk);
        #1;
        s   = mdio_pad;
        mdc = 1'b1;
        repeat (5) @(posedge mclk);
        #1;
    endtask

    task automatic finish_frame(input bit drives);
        mdc       = 1'b0;
        master_oe = 1'b0;
        repeat (5) @(posedge mclk);
        #1;
        if (drives) check("en_released", 32'(mdio_out_en), 32'd0);
        en_ok = 1'b0;
    endtask

    task automatic reset_abort();
        check("en_before_reset", 32'(mdio_out_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_en", 32'(mdio_out_en), 32'd0);
        check("reset_outs", {25'h0, mdio_out, reg_wr, reg_rd, frame_err, reg_addr == 5'h0, reg_wdata == 16'h0},
              32'h3);
        repeat (3) @(posedge mclk);
        #1;
        reset_n   = 1'b1;
        en_ok     = 1'b0;
        master_oe = 1'b0;
    endtask

    task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                              input logic [15:0] rv, input int abort_after);
        logic        s;
        logic [17:0] word;
        bit          drives;
        bit          want_data;
        model(pre, st, op, phy, ra, wd, rv, abort_after, drives, want_data);
        rd_value = rv;
        word     = '0;
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, s);
        mbit(1'b1, st[1], s);
        mbit(1'b1, st[0], s);
        if (st != 2'b01) begin finish_frame(1'b0); return; end
        mbit(1'b1, op[1], s);
        mbit(1'b1, op[0], s);
        if (!(op == 2'b10 || op == 2'b01)) begin finish_frame(1'b0); return; end
        for (int i = 4; i >= 0; i--) mbit(1'b1, phy[i], s);
        for (int i = 4; i >= 0; i--) mbit(1'b1, ra[i], s);
        if (op == 2'b10) begin
            en_ok = drives;
            for (int i = 0; i < 18; i++) begin
                mbit(1'b0, 1'b0, s);
                word = {word[16:0], s};
                if (abort_after > 0 && i == abort_after + 1) begin
                    reset_abort();
                    return;
                end
            end
            if (want_data) begin
                rd_word   = word;
                rd_word_v = 1'b1;
                @(posedge mclk);
                #1;
                rd_word_v = 1'b0;
            end
        end else begin
            mbit(1'b1, 1'b1, s);
            mbit(1'b1, 1'b0, s);
            for (int i = 15; i >= 0; i--) mbit(1'b1, wd[i], s);
        end
        finish_frame(drives);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [4:0] phy;
        int         sel;

        repeat (4) @(posedge mclk);
        #1;
        check("rst_mdio_out", 32'(mdio_out), 32'd0);
        check("rst_mdio_en", 32'(mdio_out_en), 32'd0);
        check("rst_strobes", {29'h0, reg_wr, reg_rd, frame_err}, 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge mclk);
        #1;

        send_frame(32, 2'b01, 2'b01, 5'h03, 5'h0A, 16'hA5C3, 16'h0000, 0);
        send_frame(32, 2'b01, 2'b10, 5'h03, 5'h0A, 16'h0000, 16'h1234, 0);
        send_frame(32, 2'b01, 2'b10, 5'h04, 5'h0A, 16'h0000, 16'hBEEF, 0);
        send_frame(32, 2'b01, 2'b01, 5'h04, 5'h0A, 16'h5555, 16'h0000, 0);
        send_frame(31, 2'b01, 2'b01, 5'h03, 5'h0A, 16'h0F0F, 16'h0000, 0);
        send_frame(32, 2'b01, 2'b01, 5'h03, 5'h0B, 16'h0F0F, 16'h0000, 0);
        send_frame(32, 2'b01, 2'b11, 5'h03, 5'h0C, 16'h0000, 16'h0000, 0);
        send_frame(32, 2'b01, 2'b01, 5'h03, 5'h11, 16'hC0DE, 16'h0000, 0);
        send_frame(32, 2'b00, 2'b01, 5'h03, 5'h12, 16'h0000, 16'h0000, 0);
        send_frame(32, 2'b01, 2'b10, 5'h03, 5'h05, 16'h0000, 16'h9A5A, 8);
        send_frame(32, 2'b01, 2'b10, 5'h03, 5'h06, 16'h0000, 16'h8001, 0);

        for (int n = 0; n < 20; n++) begin
            sel = int'($urandom_range(0, 7));
            op  = (sel < 3) ? 2'b01 : (sel < 6) ? 2'b10 : (sel == 6) ? 2'b11 : 2'b00;
            phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : CFG;
            send_frame(int'($urandom_range(32, 40)), 2'b01, op, phy, 5'($urandom),
                       16'($urandom), 16'($urandom), 0);
        end

        repeat (20) @(posedge mclk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("en_violations", 32'(en_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
